// File: rtl/uart_cmd_regs.sv
// uart_cmd_regs: framed UART command parser with an 8-bit register bank.
// Packet: SYNC_BYTE, CMD ('W' write / 'R' read), ADDR, DATA [, CSUM].
// Build option UART_CMD_REGS_CHECKSUM_EN adds a CSUM byte equal to CMD^ADDR^DATA.
module uart_cmd_regs #(
    parameter int          NUM_REGS     = 4,
    parameter int          TIMEOUT_CLKS = 25000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    input  logic                  i_TX_Active,
    input  logic                  i_TX_Done,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    output logic [8*NUM_REGS-1:0] o_Regs,
    output logic                  o_Busy,
    output logic [7:0]            o_Err_Count
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] TO_TERM = CW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;

`ifdef UART_CMD_REGS_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_CSUM, S_EXEC, S_RESP_WAIT} t_state;
`else
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_EXEC, S_RESP_WAIT} t_state;
`endif

    t_state          r_state;
    logic [7:0]      r_cmd;
    logic [7:0]      r_addr;
    logic [7:0]      r_data;
    logic [7:0]      r_regs [NUM_REGS];
    logic [CW-1:0]   r_to_cnt;
    logic [7:0]      r_err;
    logic            r_tx_dv;
    logic [7:0]      r_tx_byte;
    logic            r_busy;
`ifdef UART_CMD_REGS_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    logic            w_capture;
    logic            w_timeout;
    logic            w_exec_go;
    logic            w_cmd_ok;
    logic            w_addr_ok;
    logic            w_csum_ok;
    logic            w_valid;
    logic            w_drop;
    logic [1:0]      w_err_inc;
    logic [8:0]      w_err_sum;
    logic [AW-1:0]   w_idx;

    // Decode packet validity, timeout and error-increment conditions
    always_comb begin
        w_capture = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA)
`ifdef UART_CMD_REGS_CHECKSUM_EN
                    || (r_state == S_CSUM)
`endif
                    ;
        // A byte arriving on the terminal cycle wins over the timeout
        w_timeout = w_capture && !i_RX_DV && (r_to_cnt == TO_TERM);
        w_exec_go = (r_state == S_EXEC) && !i_TX_Active;
        w_cmd_ok  = (r_cmd == CMD_WRITE) || (r_cmd == CMD_READ);
        w_addr_ok = (r_addr < 8'(NUM_REGS));
`ifdef UART_CMD_REGS_CHECKSUM_EN
        w_csum_ok = (r_csum == (r_cmd ^ r_addr ^ r_data));
`else
        w_csum_ok = 1'b1;
`endif
        w_valid   = w_cmd_ok && w_addr_ok && w_csum_ok;
        w_drop    = i_RX_DV && ((r_state == S_EXEC) || (r_state == S_RESP_WAIT));
        // NAK and a dropped byte can coincide in EXEC, so the increment may be 2
        w_err_inc = {1'b0, w_timeout} + {1'b0, w_exec_go && !w_valid} + {1'b0, w_drop};
        w_err_sum = {1'b0, r_err} + {7'd0, w_err_inc};
        w_idx     = r_addr[AW-1:0];
    end

    // Inter-byte timeout counter: cleared by any byte, runs only while collecting a packet
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            r_to_cnt <= '0;
        else if (i_RX_DV || !w_capture || w_timeout)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + CW'(1);
    end

    // Saturating protocol error counter
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            r_err <= '0;
        else
            r_err <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
    end

    // Packet FSM with registered response, busy flag and register bank writes
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state   <= S_IDLE;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
            r_busy    <= 1'b0;
`ifdef UART_CMD_REGS_CHECKSUM_EN
            r_csum    <= '0;
`endif
            for (int unsigned i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else begin
            r_tx_dv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
                        r_state <= S_CMD;
                        r_busy  <= 1'b1;
                    end
                end
                S_CMD: begin
                    if (i_RX_DV) begin
                        r_cmd   <= i_RX_Byte;
                        r_state <= S_ADDR;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (i_RX_DV) begin
                        r_addr  <= i_RX_Byte;
                        r_state <= S_DATA;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (i_RX_DV) begin
                        r_data  <= i_RX_Byte;
`ifdef UART_CMD_REGS_CHECKSUM_EN
                        r_state <= S_CSUM;
`else
                        r_state <= S_EXEC;
`endif
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
`ifdef UART_CMD_REGS_CHECKSUM_EN
                S_CSUM: begin
                    if (i_RX_DV) begin
                        r_csum  <= i_RX_Byte;
                        r_state <= S_EXEC;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                S_EXEC: begin
                    if (!i_TX_Active) begin
                        r_tx_dv <= 1'b1;
                        r_state <= S_RESP_WAIT;
                        if (!w_valid)
                            r_tx_byte <= RESP_NAK;
                        else if (r_cmd == CMD_WRITE) begin
                            r_regs[w_idx] <= r_data;
                            r_tx_byte     <= RESP_ACK;
                        end else
                            r_tx_byte <= r_regs[w_idx];
                    end
                end
                S_RESP_WAIT: begin
                    if (i_TX_Done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign o_Regs[8*g +: 8] = r_regs[g];
    end

    assign o_TX_DV     = r_tx_dv;
    assign o_TX_Byte   = r_tx_byte;
    assign o_Busy      = r_busy;
    assign o_Err_Count = r_err;

endmodule

// File: tb/tb_uart_cmd_regs.sv
// Directed bench for uart_cmd_regs: table of packets plus hand-written
// sequences for timeout, byte/timeout race, TX stall, saturation and reset abort.
module tb_uart_cmd_regs;

    localparam int NR = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          tx_active;
    logic          tx_done;
    logic          o_tx_dv;
    logic [7:0]    o_tx_byte;
    logic [8*NR-1:0] o_regs;
    logic          o_busy;
    logic [7:0]    o_err;

    int checks = 0;
    int errors = 0;
    int tx_dv_seen = 0;
    logic [31:0] exp_regs;
    int unsigned exp_err;

    uart_cmd_regs #(.NUM_REGS(NR), .TIMEOUT_CLKS(TO), .SYNC_BYTE(8'hA5)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
        .i_TX_Active(tx_active), .i_TX_Done(tx_done),
        .o_TX_DV(o_tx_dv), .o_TX_Byte(o_tx_byte), .o_Regs(o_regs),
        .o_Busy(o_busy), .o_Err_Count(o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (o_tx_dv) tx_dv_seen++;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [7:0]  resp;
        logic [31:0] regs;
        int unsigned err;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input bit bad_cs);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(d);
`ifdef UART_CMD_REGS_CHECKSUM_EN
        send_byte(bad_cs ? 8'h00 : (c ^ a ^ d));
`endif
    endtask

    task automatic finish_tx();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("busy_after_done", 32'(o_busy), 32'd0);
    endtask

    // Called right after the final byte: FSM sits in EXEC, response at N+2, pulse ends at N+3
    task automatic check_response(input logic [7:0] resp, input logic [31:0] regs, input int unsigned err);
        chk("exec_no_dv", 32'(o_tx_dv), 32'd0);
        chk("busy_exec", 32'(o_busy), 32'd1);
        @(negedge clk);
        chk("tx_dv", 32'(o_tx_dv), 32'd1);
        chk("tx_byte", 32'(o_tx_byte), 32'(resp));
        chk("regs", o_regs, regs);
        chk("err_count", 32'(o_err), 32'(err));
        @(negedge clk);
        chk("tx_dv_one_cycle", 32'(o_tx_dv), 32'd0);
        chk("tx_byte_hold", 32'(o_tx_byte), 32'(resp));
        chk("busy_resp_wait", 32'(o_busy), 32'd1);
        finish_tx();
    endtask

    initial begin
        vecs[0] = '{8'h57, 8'h02, 8'h3C, 8'h06, 32'h003C_0000, 0};
        vecs[1] = '{8'h52, 8'h02, 8'h00, 8'h3C, 32'h003C_0000, 0};
        vecs[2] = '{8'h57, 8'h07, 8'h11, 8'h15, 32'h003C_0000, 1};
        vecs[3] = '{8'h99, 8'h00, 8'h00, 8'h15, 32'h003C_0000, 2};
        vecs[4] = '{8'h57, 8'h00, 8'hAB, 8'h06, 32'h003C_00AB, 2};
        vecs[5] = '{8'h57, 8'h03, 8'hFF, 8'h06, 32'hFF3C_00AB, 2};
        vecs[6] = '{8'h52, 8'h00, 8'h00, 8'hAB, 32'hFF3C_00AB, 2};
        vecs[7] = '{8'h52, 8'h04, 8'h00, 8'h15, 32'hFF3C_00AB, 3};
        vecs[8] = '{8'h57, 8'h03, 8'h00, 8'h06, 32'h003C_00AB, 3};

        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; tx_active = 1'b0; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_regs", o_regs, 32'd0);
        chk("rst_tx_dv", 32'(o_tx_dv), 32'd0);
        chk("rst_tx_byte", 32'(o_tx_byte), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);

        // Non-sync bytes in IDLE are ignored silently
        send_byte(8'h57);
        send_byte(8'h00);
        chk("idle_discard_busy", 32'(o_busy), 32'd0);
        chk("idle_discard_err", 32'(o_err), 32'd0);

        // Busy rises the cycle after the sync byte
        send_byte(8'hA5);
        chk("busy_after_sync", 32'(o_busy), 32'd1);
        send_byte(8'h57); send_byte(8'h02); send_byte(8'h3C);
`ifdef UART_CMD_REGS_CHECKSUM_EN
        send_byte(8'h57 ^ 8'h02 ^ 8'h3C);
`endif
        check_response(vecs[0].resp, vecs[0].regs, vecs[0].err);

        for (int i = 1; i < 9; i++) begin
            send_pkt(vecs[i].cmd, vecs[i].addr, vecs[i].data, 1'b0);
            check_response(vecs[i].resp, vecs[i].regs, vecs[i].err);
        end
        exp_regs = 32'h003C_00AB;
        exp_err  = 3;

`ifdef UART_CMD_REGS_CHECKSUM_EN
        send_pkt(8'h57, 8'h01, 8'h10, 1'b1);
        exp_err++;
        check_response(8'h15, exp_regs, exp_err);
        send_pkt(8'h57, 8'h01, 8'h10, 1'b0);
        exp_regs[15:8] = 8'h10;
        check_response(8'h06, exp_regs, exp_err);
`endif

        // Timeout: last DV at edge E, FSM abandons the packet at edge E+TO
        begin
            int seen0;
            seen0 = tx_dv_seen;
            send_byte(8'hA5);
            send_byte(8'h57);
            repeat (TO - 1) @(negedge clk);
            chk("timeout_busy_before", 32'(o_busy), 32'd1);
            @(negedge clk);
            exp_err++;
            chk("timeout_busy_after", 32'(o_busy), 32'd0);
            chk("timeout_err", 32'(o_err), 32'(exp_err));
            repeat (4) @(negedge clk);
            chk("timeout_no_tx", 32'(tx_dv_seen - seen0), 32'd0);
            chk("timeout_regs", o_regs, exp_regs);
        end

        // Race: ADDR byte lands exactly on the terminal-count cycle and must be kept
        send_byte(8'hA5);
        send_byte(8'h57);
        repeat (TO - 2) @(negedge clk);
        send_byte(8'h01);
        chk("race_busy", 32'(o_busy), 32'd1);
        send_byte(8'h5A);
`ifdef UART_CMD_REGS_CHECKSUM_EN
        send_byte(8'h57 ^ 8'h01 ^ 8'h5A);
`endif
        exp_regs[15:8] = 8'h5A;
        check_response(8'h06, exp_regs, exp_err);

        // TX busy stalls EXEC; a byte arriving meanwhile is dropped and counted
        tx_active = 1'b1;
        send_pkt(8'h52, 8'h01, 8'h00, 1'b0);
        send_byte(8'h33);
        exp_err++;
        repeat (2) @(negedge clk);
        chk("stall_no_dv", 32'(o_tx_dv), 32'd0);
        chk("stall_busy", 32'(o_busy), 32'd1);
        chk("stall_drop_err", 32'(o_err), 32'(exp_err));
        tx_active = 1'b0;
        @(negedge clk);
        chk("stall_tx_dv", 32'(o_tx_dv), 32'd1);
        chk("stall_tx_byte", 32'(o_tx_byte), 32'h5A);
        @(negedge clk);
        chk("stall_dv_one_cycle", 32'(o_tx_dv), 32'd0);
        finish_tx();

        // Saturation: flood dropped bytes while waiting for TX completion
        send_pkt(8'h52, 8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 260; i++) send_byte(8'h77);
        chk("err_saturate", 32'(o_err), 32'hFF);
        chk("sat_regs", o_regs, exp_regs);
        finish_tx();
        chk("err_stays_sat", 32'(o_err), 32'hFF);

        // Reset mid-packet: asynchronous abort to reset values
        send_byte(8'hA5); send_byte(8'h57); send_byte(8'h01);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_regs", o_regs, 32'd0);
        chk("async_rst_err", 32'(o_err), 32'd0);
        chk("async_rst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h22);
        chk("post_rst_regs", o_regs, 32'd0);
        chk("post_rst_busy", 32'(o_busy), 32'd0);
        chk("post_rst_tx_byte", 32'(o_tx_byte), 32'd0);

        send_pkt(8'h57, 8'h02, 8'h3C, 1'b0);
        check_response(8'h06, 32'h003C_0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
